// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, default
// latencies and the controller state type.
package mult_div_unit_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_arith_op(input logic [3:0] op);
        return (op <= OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_calc.sv
// Combinational arithmetic core: produces the HI/LO result of a mult/multu/
// div/divu on A,B and flags a zero divisor.
module mult_div_unit_calc
    import mult_div_unit_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div0
);

    logic signed [63:0] prod_signed_s;
    logic        [63:0] prod_unsigned_s;
    logic        [31:0] a_mag_s;
    logic        [31:0] b_mag_s;
    logic        [31:0] num_s;
    logic        [31:0] den_s;
    logic        [31:0] quo_s;
    logic        [31:0] rem_s;
    logic               signed_div_s;

    assign prod_signed_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_unsigned_s = {32'd0, a} * {32'd0, b};

    // Signed division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
    assign signed_div_s = (op == OP_DIV);
    assign a_mag_s      = a[31] ? (32'd0 - a) : a;
    assign b_mag_s      = b[31] ? (32'd0 - b) : b;
    assign num_s        = signed_div_s ? a_mag_s : a;
    assign div0         = (b == 32'd0);
    assign den_s        = div0 ? 32'd1 : (signed_div_s ? b_mag_s : b);
    assign quo_s        = num_s / den_s;
    assign rem_s        = num_s % den_s;

    // Result selection; signs are re-applied to the signed-divide magnitudes.
    always_comb begin
        hi_res = 32'd0;
        lo_res = 32'd0;
        case (op)
            OP_MULT: begin
                hi_res = prod_signed_s[63:32];
                lo_res = prod_signed_s[31:0];
            end
            OP_MULTU: begin
                hi_res = prod_unsigned_s[63:32];
                lo_res = prod_unsigned_s[31:0];
            end
            OP_DIV: begin
                lo_res = (a[31] ^ b[31]) ? (32'd0 - quo_s) : quo_s;
                hi_res = a[31] ? (32'd0 - rem_s) : rem_s;
            end
            OP_DIVU: begin
                lo_res = quo_s;
                hi_res = rem_s;
            end
            default: begin
                hi_res = 32'd0;
                lo_res = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage HI/LO multiply/divide unit: accepts one arithmetic op at a time,
// holds busy for a fixed latency, then commits the result into HI/LO.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  MULTDIVControl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e          state_r;
    md_state_e          state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [31:0]        hi_r;
    logic [31:0]        hi_nxt_s;
    logic [31:0]        lo_r;
    logic [31:0]        lo_nxt_s;
    logic [31:0]        hi_pend_r;
    logic [31:0]        hi_pend_nxt_s;
    logic [31:0]        lo_pend_r;
    logic [31:0]        lo_pend_nxt_s;
    logic               div0_r;
    logic               div0_nxt_s;

    logic [31:0]        hi_res_s;
    logic [31:0]        lo_res_s;
    logic               div0_s;

    mult_div_unit_calc u_calc (
        .a      (A),
        .b      (B),
        .op     (MULTDIVControl),
        .hi_res (hi_res_s),
        .lo_res (lo_res_s),
        .div0   (div0_s)
    );

    assign busy = (state_r == ST_BUSY);
    assign HI   = hi_r;
    assign LO   = lo_r;

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath-update decisions; anything while BUSY other than the countdown is ignored.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        hi_nxt_s      = hi_r;
        lo_nxt_s      = lo_r;
        hi_pend_nxt_s = hi_pend_r;
        lo_pend_nxt_s = lo_pend_r;
        div0_nxt_s    = div0_r;
        case (state_r)
            ST_IDLE: begin
                if (start && is_arith_op(MULTDIVControl)) begin
                    state_nxt_s   = ST_BUSY;
                    cnt_nxt_s     = is_div_op(MULTDIVControl) ? DIV_LOAD : MULT_LOAD;
                    hi_pend_nxt_s = hi_res_s;
                    lo_pend_nxt_s = lo_res_s;
                    div0_nxt_s    = is_div_op(MULTDIVControl) && div0_s;
                end else if (MULTDIVControl == OP_MTHI) begin
                    hi_nxt_s = A;
                end else if (MULTDIVControl == OP_MTLO) begin
                    lo_nxt_s = A;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_IDLE;
                    if (!div0_r) begin
                        hi_nxt_s = hi_pend_r;
                        lo_nxt_s = lo_pend_r;
                    end else begin
                        hi_nxt_s = hi_r;
                        lo_nxt_s = lo_r;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Counter, HI/LO and pending-result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CNT_W{1'b0}};
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            hi_pend_r <= 32'd0;
            lo_pend_r <= 32'd0;
            div0_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            hi_r      <= hi_nxt_s;
            lo_r      <= lo_nxt_s;
            hi_pend_r <= hi_pend_nxt_s;
            lo_pend_r <= lo_pend_nxt_s;
            div0_r    <= div0_nxt_s;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus random
// traffic compared against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  ctl;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_phi;
    logic [31:0] m_plo;
    bit          m_pdiv0;
    int          m_left;

    mult_div_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .MULTDIVControl (ctl),
        .A              (a_in),
        .B              (b_in),
        .busy           (busy),
        .HI             (hi),
        .LO             (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic straight from the instruction definitions.
    function automatic void ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] r_hi, output logic [31:0] r_lo);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        r_hi = 32'd0;
        r_lo = 32'd0;
        case (op)
            4'd0: begin p = sa * sb; r_hi = p[63:32]; r_lo = p[31:0]; end
            4'd1: begin up = ua * ub; r_hi = up[63:32]; r_lo = up[31:0]; end
            4'd2: if (b != 32'd0) begin q = sa / sb; r = sa % sb; r_hi = r[31:0]; r_lo = q[31:0]; end
            4'd3: if (b != 32'd0) begin uq = ua / ub; ur = ua % ub; r_hi = ur[31:0]; r_lo = uq[31:0]; end
            default: begin r_hi = 32'd0; r_lo = 32'd0; end
        endcase
    endfunction

    function automatic void model_reset();
        m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0;
        m_pdiv0 = 1'b0; m_left = 0;
    endfunction

    function automatic void model_edge(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && !m_pdiv0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (s && op <= 4'd3) begin
            ref_result(op, a, b, m_phi, m_plo);
            m_pdiv0 = (op >= 4'd2) && (b == 32'd0);
            m_left  = (op >= 4'd2) ? 10 : 5;
        end else if (op == 4'd4) begin
            m_hi = a;
        end else if (op == 4'd5) begin
            m_lo = a;
        end
    endfunction

    task automatic tick(input string tag, input logic s, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        start = s; ctl = op; a_in = a; b_in = b;
        @(posedge clk);
        model_edge(s, op, a, b);
        @(negedge clk);
        check_val({tag, "_busy"}, {31'd0, busy}, {31'd0, (m_left > 0)});
        check_val({tag, "_hi"}, hi, m_hi);
        check_val({tag, "_lo"}, lo, m_lo);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag, 1'b0, 4'd0, $urandom, $urandom);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  rop;
        logic        rs;
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst_n = 1'b0; start = 1'b0; ctl = 4'd0; a_in = 32'd0; b_in = 32'd0;
        repeat (2) @(negedge clk);
        check_val("reset_busy", {31'd0, busy}, 32'd0);
        check_val("reset_hi", hi, 32'd0);
        check_val("reset_lo", lo, 32'd0);
        rst_n = 1'b1;

        // 1: signed multiply
        tick("mult", 1'b1, 4'd0, 32'hFFFF_FFFE, 32'd3);
        idle("mult_wait", 5);
        check_val("mult_hi_const", hi, 32'hFFFF_FFFF);
        check_val("mult_lo_const", lo, 32'hFFFF_FFFA);

        // 2: unsigned multiply
        tick("multu", 1'b1, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle("multu_wait", 5);
        check_val("multu_hi_const", hi, 32'hFFFF_FFFE);
        check_val("multu_lo_const", lo, 32'h0000_0001);

        // 3: signed divide, then divide by zero leaves HI/LO alone
        tick("div", 1'b1, 4'd2, 32'hFFFF_FFF9, 32'd2);
        idle("div_wait", 10);
        check_val("div_lo_const", lo, 32'hFFFF_FFFD);
        check_val("div_hi_const", hi, 32'hFFFF_FFFF);
        tick("divu0", 1'b1, 4'd3, 32'd7, 32'd0);
        idle("divu0_wait", 10);
        check_val("divu0_lo_const", lo, 32'hFFFF_FFFD);
        check_val("divu0_hi_const", hi, 32'hFFFF_FFFF);

        // overflow case of signed divide
        tick("div_ovf", 1'b1, 4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        idle("div_ovf_wait", 10);
        check_val("div_ovf_lo_const", lo, 32'h8000_0000);
        check_val("div_ovf_hi_const", hi, 32'h0000_0000);

        // 4: mthi / mtlo back to back
        tick("mthi", 1'b0, 4'd4, 32'h1234_5678, 32'd0);
        tick("mtlo", 1'b0, 4'd5, 32'h9ABC_DEF0, 32'd0);
        check_val("mthi_const", hi, 32'h1234_5678);
        check_val("mtlo_const", lo, 32'h9ABC_DEF0);

        // 5: reset in the middle of a divide
        tick("rst_div", 1'b1, 4'd2, 32'd1000, 32'd3);
        idle("rst_div_wait", 3);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_hi", hi, 32'd0);
        check_val("midrst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick("post_rst_mult", 1'b1, 4'd0, 32'd12345, 32'hFFFF_FF00);
        idle("post_rst_wait", 5);

        // 6: start while busy is ignored
        tick("busy_div", 1'b1, 4'd2, 32'd100, 32'd7);
        tick("busy_mult", 1'b1, 4'd0, 32'd3, 32'd3);
        tick("busy_mthi", 1'b0, 4'd4, 32'hDEAD_BEEF, 32'd0);
        idle("busy_wait", 8);
        check_val("busy_lo_const", lo, 32'd14);
        check_val("busy_hi_const", hi, 32'd2);

        // back-to-back: new op on the cycle busy drops
        tick("b2b_multu", 1'b1, 4'd1, 32'd6, 32'd7);
        idle("b2b_wait", 4);
        tick("b2b_divu", 1'b1, 4'd3, 32'd50, 32'd8);
        idle("b2b_divu_wait", 10);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rop = 4'($urandom_range(0, 9));
            rs  = ($urandom_range(0, 2) == 0) && (rop <= 4'd3);
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            tick("rand", rs, rop, ra, rb);
        end
        idle("drain", 12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
